gpio_input_reader: RTL and testbench

- Memory-mapped input port for the board buttons/switches; the CPU tile reads it over its simple data-memory bus.
- Per bit: 2-flop synchroniser, debounce counter, rising/falling edge detection, sticky write-1-to-clear event flags.
- Sits next to the LED output logic in the tile's peripheral space; shares the single system clock and reset from the clock wizard domain.

---
 rtl/gpio_input_reader_if.sv | 25 ++
 rtl/gpio_input_reader.sv | 133 +++++++++++++
 tb/tb_gpio_input_reader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_input_reader_if.sv
// ============================================================================
// gpio_input_reader_if: simple data-memory bus between CPU tile and GPIO input port. Rev 1.0
// ============================================================================
`default_nettype none

interface gpio_input_reader_if;
  logic        mem_valid;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/gpio_input_reader.sv
// ============================================================================
// gpio_input_reader: synchronised, debounced inputs with sticky W1C edge flags.
// Define GPIO_INPUT_IRQ_EN to implement IRQ_EN and irq. Rev 1.0
// ============================================================================
`default_nettype none

module gpio_input_reader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     pin_in,
  gpio_input_reader_if.slave   bus,
  output logic                 irq
);

  localparam logic [1:0] ADDR_STATE  = 2'd0;
  localparam logic [1:0] ADDR_RISE   = 2'd1;
  localparam logic [1:0] ADDR_FALL   = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] done;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [WIDTH-1:0] clr_rise;
  logic [WIDTH-1:0] clr_fall;
  logic [31:0]      rd_word;
  logic             wr_acc;
  logic             unused_wdata;

  assign unused_wdata = ^bus.mem_wdata[31:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // done[i] marks the last cycle of an unbroken mismatch run: the level flips at this edge
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    assign mismatch = sync2[i] ^ state[i];
    assign done[i]  = mismatch && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (!mismatch || done[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise_evt = done & sync2;
  assign fall_evt = done & ~sync2;

  assign wr_acc   = bus.mem_valid && bus.mem_we;
  assign clr_rise = (wr_acc && bus.mem_addr == ADDR_RISE) ? bus.mem_wdata[WIDTH-1:0] : '0;
  assign clr_fall = (wr_acc && bus.mem_addr == ADDR_FALL) ? bus.mem_wdata[WIDTH-1:0] : '0;

  // Event set is OR-ed after the clear so a same-cycle set wins over W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      state <= state ^ done;
      rise  <= (rise & ~clr_rise) | rise_evt;
      fall  <= (fall & ~clr_fall) | fall_evt;
    end
  end

`ifdef GPIO_INPUT_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_acc && bus.mem_addr == ADDR_IRQ_EN) begin
        irq_en <= bus.mem_wdata[WIDTH-1:0];
      end
      irq <= |((rise | fall) & irq_en);
    end
  end
`else
  assign irq_en = '0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (bus.mem_addr)
      ADDR_STATE:  rd_word[WIDTH-1:0] = state;
      ADDR_RISE:   rd_word[WIDTH-1:0] = rise;
      ADDR_FALL:   rd_word[WIDTH-1:0] = fall;
      ADDR_IRQ_EN: rd_word[WIDTH-1:0] = irq_en;
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_rdata <= '0;
      bus.mem_ready <= 1'b0;
    end else begin
      bus.mem_ready <= bus.mem_valid;
      if (bus.mem_valid) begin
        bus.mem_rdata <= bus.mem_we ? 32'd0 : rd_word;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_input_reader.sv
// ============================================================================
// tb_gpio_input_reader: scoreboard bench with a behavioural model of gpio_input_reader. Rev 1.0
// ============================================================================
`default_nettype none

module tb_gpio_input_reader;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pin_in = '0;
  logic         irq;

  gpio_input_reader_if bus ();

  gpio_input_reader #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pin_in(pin_in),
    .bus(bus.slave),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: level flips once the last D synchronised samples all disagree with it
  logic [W-1:0] m_state = '0;
  logic [W-1:0] m_rise  = '0;
  logic [W-1:0] m_fall  = '0;
  logic [W-1:0] m_ien   = '0;
  logic         m_irq   = 1'b0;
  logic [W-1:0] pin_q[$];
  logic [W-1:0] sync_q[$];
  logic [W-1:0] cur;

  function automatic logic [31:0] reg_val(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_state};
      2'd1:    return {28'd0, m_rise};
      2'd2:    return {28'd0, m_fall};
      default: return {28'd0, m_ien};
    endcase
  endfunction

  task automatic step(input logic r, input logic [W-1:0] p, input logic v,
                      input logic we, input logic [1:0] a, input logic [31:0] wd);
    logic [W-1:0] sync, flip, nstate, clr_r, clr_f;
    exp_t e;
    rst           = r;
    pin_in        = p;
    bus.mem_valid = v;
    bus.mem_we    = we;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    if (!r && v) begin
      e.cyc  = cyc;
      e.data = we ? 32'd0 : reg_val(a);
      sb.push_back(e);
    end
    sync = (pin_q.size() >= 2) ? pin_q[pin_q.size()-2] : '0;
    sync_q.push_back(sync);
    if (sync_q.size() > D) void'(sync_q.pop_front());
    flip = '0;
    if (sync_q.size() == D) begin
      for (int i = 0; i < W; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        foreach (sync_q[j]) if (sync_q[j][i] == m_state[i]) all_diff = 1'b0;
        flip[i] = all_diff;
      end
    end
    nstate = m_state ^ flip;
    clr_r  = (v && we && a == 2'd1) ? wd[W-1:0] : '0;
    clr_f  = (v && we && a == 2'd2) ? wd[W-1:0] : '0;
    @(posedge clk);
    if (r) begin
      m_state = '0; m_rise = '0; m_fall = '0; m_ien = '0; m_irq = 1'b0;
      pin_q.delete();
      sync_q.delete();
    end else begin
      m_irq  = |((m_rise | m_fall) & m_ien);
      m_rise = (m_rise & ~clr_r) | (flip & nstate);
      m_fall = (m_fall & ~clr_f) | (flip & ~nstate);
`ifdef GPIO_INPUT_IRQ_EN
      if (v && we && a == 2'd3) m_ien = wd[W-1:0];
`endif
      m_state = nstate;
      pin_q.push_back(p);
      if (pin_q.size() > 2) void'(pin_q.pop_front());
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, cur, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b0, cur, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, cur, 1'b1, 1'b1, a, d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (irq !== m_irq) begin
      n_bad++;
      $display("FAIL irq cyc=%0d got=%b want=%b", cyc, irq, m_irq);
    end
    if (bus.mem_ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_ready cyc=%0d got=1 want=0", cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc - 1 || bus.mem_rdata !== e.data) begin
          n_bad++;
          $display("FAIL rdata cyc=%0d issued=%0d got=%h want=%h", cyc, e.cyc, bus.mem_rdata, e.data);
        end
      end
    end else if (bus.mem_ready !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_x cyc=%0d got=%b want=0/1", cyc, bus.mem_ready);
    end
    while (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_ready cyc=%0d issued=%0d got=0 want=1", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 2'd0;
    bus.mem_wdata = 32'd0;
    cur = 4'h0;
    repeat (3) step(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    for (int a = 0; a < 4; a++) rd(2'(a));
    idle(2);

    // Rising step on bit 0, STATE read every cycle across the latency window
    cur = 4'h1;
    repeat (10) rd(2'd0);
    rd(2'd1);
    rd(2'd2);

    // 3-cycle glitch on bit 1
    cur = 4'h3;
    repeat (3) rd(2'd0);
    cur = 4'h1;
    repeat (8) rd(2'd0);
    rd(2'd1);
    rd(2'd2);

    // Release bit 0, then W1C behaviour on FALL
    cur = 4'h0;
    idle(8);
    rd(2'd2);
    wr(2'd2, 32'h0);
    rd(2'd2);
    wr(2'd2, 32'h1);
    rd(2'd2);
    wr(2'd1, 32'hF);

    // Clear RISE[2] in the very cycle bit 2 is debounced high
    cur = 4'h4;
    idle(5);
    wr(2'd1, 32'h4);
    rd(2'd1);
    idle(2);

    wr(2'd3, 32'h8);
    cur = 4'hC;
    idle(10);
    rd(2'd1);
    wr(2'd1, 32'h8);
    idle(3);
    rd(2'd3);

    // Randomised slow pin activity with random bus traffic and rare resets
    for (int n = 0; n < 1500; n++) begin
      logic r, v, we;
      logic [1:0] a;
      for (int b = 0; b < W; b++) if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 1) == 1);
      we = ($urandom_range(0, 3) == 0);
      a  = 2'($urandom_range(0, 3));
      step(r, cur, v, we, a, $urandom);
    end
    idle(4);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL pending_responses got=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
